// File: rtl/sq_dist_gen_if.sv
// Output stream of the squared-distance generator: one element result per
// valid/ready transfer, tagged with its element index and an end-of-sweep flag.
interface sq_dist_gen_if;
  logic [31:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  elem_idx;
  logic        last;

  modport master (output dout, output out_valid, output elem_idx, output last, input out_ready);
  modport slave  (input dout, input out_valid, input elem_idx, input last, output out_ready);
endinterface

// File: rtl/sq_dist_gen.sv
// Squared-distance generator: for one focal point, walks every array element
// and streams (x_f - xe)^2 + z_f^2, saturated to 32 bits, to the sqrt stage.
module sq_dist_gen #(
  parameter int N_ELEM  = 64,
  parameter int ELEM_X0 = -63,
  parameter int PITCH   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [15:0] x_f,
  input  logic signed [15:0] z_f,
  sq_dist_gen_if.master      ds,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, LATCH, DIFF, SQUARE, SUM, OUT, NEXT, DONE} state_t;

  localparam logic signed [16:0] X0_C    = 17'(ELEM_X0);
  localparam logic signed [16:0] PITCH_C = 17'(PITCH);
  localparam logic [7:0]         LAST_C  = 8'(N_ELEM - 1);

  state_t             state_r, state_s;
  logic signed [15:0] xf_r, zf_r;
  logic signed [16:0] xe_r, dx_r;
  logic [7:0]         idx_r;
  logic [31:0]        z2_r;
  logic [33:0]        dx2_r;
  logic [31:0]        dout_r;
  logic               valid_r, last_r, busy_r, done_r;

  logic signed [31:0] z2_s;
  logic signed [16:0] dx_s;
  logic signed [33:0] dx2_s;
  logic [34:0]        sum_s;

  assign z2_s  = zf_r * zf_r;
  assign dx_s  = {xf_r[15], xf_r} - xe_r;
  assign dx2_s = dx_r * dx_r;
  assign sum_s = {1'b0, dx2_r} + {3'b000, z2_r};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; one element takes DIFF..NEXT, five cycles with no backpressure
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LATCH;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH:  state_s = DIFF;
      DIFF:   state_s = SQUARE;
      SQUARE: state_s = SUM;
      SUM:    state_s = OUT;
      OUT: begin
        if (ds.out_ready && last_r) begin
          state_s = DONE;
        end else if (ds.out_ready) begin
          state_s = NEXT;
        end else begin
          state_s = OUT;
        end
      end
      NEXT:    state_s = DIFF;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath pipeline and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xf_r    <= 16'sd0;
      zf_r    <= 16'sd0;
      xe_r    <= 17'sd0;
      dx_r    <= 17'sd0;
      idx_r   <= 8'd0;
      z2_r    <= 32'd0;
      dx2_r   <= 34'd0;
      dout_r  <= 32'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      // done is registered off DONE, so the pulse lands the cycle after it
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            xf_r  <= x_f;
            zf_r  <= z_f;
            idx_r <= 8'd0;
            xe_r  <= X0_C;
          end
        end
        LATCH:  z2_r  <= $unsigned(z2_s);
        DIFF:   dx_r  <= dx_s;
        SQUARE: dx2_r <= $unsigned(dx2_s);
        SUM: begin
          dout_r  <= (|sum_s[34:32]) ? 32'hFFFF_FFFF : sum_s[31:0];
          valid_r <= 1'b1;
          last_r  <= (idx_r == LAST_C);
        end
        OUT: begin
          if (ds.out_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end
        end
        NEXT: begin
          idx_r <= idx_r + 8'd1;
          xe_r  <= xe_r + PITCH_C;
        end
        default: begin
        end
      endcase
    end
  end

  assign ds.dout      = dout_r;
  assign ds.out_valid = valid_r;
  assign ds.elem_idx  = idx_r;
  assign ds.last      = last_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_sq_dist_gen.sv
// Bench for sq_dist_gen: two parameterisations (small array, saturating array),
// directed and randomised sweeps checked against an arithmetic distance model.
module tb_sq_dist_gen;

  logic        clk = 1'b0;
  logic        reset_n, start, sel, rdy;
  logic [15:0] x_f, z_f;
  logic        busy_a, done_a, busy_b, done_b;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  sq_dist_gen_if ia ();
  sq_dist_gen_if ib ();

  assign ia.out_ready = rdy & ~sel;
  assign ib.out_ready = rdy & sel;

  sq_dist_gen #(.N_ELEM(4), .ELEM_X0(-3), .PITCH(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel), .x_f(x_f), .z_f(z_f),
    .ds(ia.master), .busy(busy_a), .done(done_a));

  sq_dist_gen #(.N_ELEM(8), .ELEM_X0(-32768), .PITCH(9000)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start & sel), .x_f(x_f), .z_f(z_f),
    .ds(ib.master), .busy(busy_b), .done(done_b));

  wire [31:0] dout_m = sel ? ib.dout      : ia.dout;
  wire        ov_m   = sel ? ib.out_valid : ia.out_valid;
  wire [7:0]  eidx_m = sel ? ib.elem_idx  : ia.elem_idx;
  wire        last_m = sel ? ib.last      : ia.last;
  wire        busy_m = sel ? busy_b       : busy_a;
  wire        done_m = sel ? done_b       : done_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact distance in wide arithmetic, then clamp to 32 bits
  function automatic longint model(input int x0, input int pitch, input int xf, input int zf, input int idx);
    longint dx, s;
    dx = longint'(xf) - (longint'(x0) + longint'(idx) * longint'(pitch));
    s  = dx * dx + longint'(zf) * longint'(zf);
    return (s > 64'sh0_FFFF_FFFF) ? 64'sh0_FFFF_FFFF : s;
  endfunction

  // One full sweep on the selected DUT; must be entered idle, #1 after a rising edge
  task automatic sweep(input int xf, input int zf, input int rdy_pct, input bit lat,
                       input int hold_idx, input int poke_cyc);
    int n, x0, pitch, cyc, idx, post, held, done_cnt, done_cyc, bound;
    bit pend;
    n     = sel ? 8 : 4;
    x0    = sel ? -32768 : -3;
    pitch = sel ? 9000 : 2;
    bound = n * 40 + 40;
    cyc = 0; idx = 0; post = 0; held = 0; done_cnt = 0; done_cyc = -1; pend = 1'b0;
    x_f = 16'(xf); z_f = 16'(zf); rdy = 1'b0; start = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) x_f = 16'd10;
      if (done_m) begin done_cnt++; done_cyc = cyc; end
      if (idx == n) begin
        post++;
        if (post >= 4) break;
      end else begin
        if (hold_idx >= 0 && ov_m && int'(eidx_m) == hold_idx && held < 10) begin
          rdy = 1'b0;
          held++;
        end else begin
          rdy = (int'($urandom_range(99)) < rdy_pct);
        end
        check("busy_mid", busy_m, 1);
        if (pend) check("valid_hold", ov_m, 1);
        if (lat) check("lat_valid", ov_m, (cyc % 5 == 0));
        if (ov_m) begin
          check("dout", dout_m, model(x0, pitch, xf, zf, idx));
          check("elem_idx", eidx_m, idx);
          check("last", last_m, (idx == n - 1));
          if (rdy) idx++;
          pend = !rdy;
        end else begin
          pend = 1'b0;
        end
      end
      if (cyc > bound) begin
        check("sweep_timeout", idx, n);
        break;
      end
    end
    rdy = 1'b0;
    check("done_count", done_cnt, 1);
    if (lat) check("done_cycle", done_cyc, 5 * n + 2);
    check("busy_end", busy_m, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sel = 1'b0; rdy = 1'b0; x_f = 16'd0; z_f = 16'd0;
    #3;
    check("rst_valid_a", ia.out_valid, 0);
    check("rst_dout_a", ia.dout, 0);
    check("rst_idx_a", ia.elem_idx, 0);
    check("rst_last_a", ia.last, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_valid_b", ib.out_valid, 0);
    check("rst_busy_b", busy_b, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Small array: nominal sweep with latency, backpressure on idx 1, start poked mid-sweep
    sweep(0, 4, 100, 1'b1, -1, -1);
    sweep(0, 4, 100, 1'b0, 1, -1);
    sweep(0, 4, 100, 1'b1, -1, 8);

    // Reset while idx 2 is presented
    x_f = 16'd0; z_f = 16'd4; rdy = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ia.out_valid && ia.elem_idx == 8'd2) break;
      @(posedge clk); #1;
    end
    check("rst_reach_idx2", ia.elem_idx, 2);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", ia.out_valid, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_idx", ia.elem_idx, 0);
    check("midrst_last", ia.last, 0);
    check("midrst_done", done_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_nodone", done_a, 0);
      check("midrst_idle", busy_a, 0);
    end
    sweep(0, 4, 100, 1'b1, -1, -1);

    for (int k = 0; k < 4; k++)
      sweep(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768, 60, 1'b0, -1, -1);

    // Wide array: saturation at idx 0, then random focal points
    sel = 1'b1;
    sweep(32767, 32767, 100, 1'b1, -1, -1);
    for (int k = 0; k < 3; k++)
      sweep(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768, 70, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
